// File: rtl/alu_arb_pkg.sv
// Shared constants for the alu arbiter: opcodes, FSM encoding, response flag layout.
package alu_arb_pkg;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_SLL = 5'd4;
   localparam logic [4:0] OP_SRA = 5'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int FLG_NE  = 0;
   localparam int FLG_LT  = 1;
   localparam int FLG_OVF = 2;
   localparam int FLG_ILL = 3;

   function automatic logic op_legal(input logic [4:0] op);
      return (op <= OP_SRA);
   endfunction

   // Only sub produces meaningful compare flags; only add/sub produce overflow.
   function automatic logic [3:0] mask_flags(input logic [4:0] op, input logic ne,
                                             input logic lt, input logic ovf);
      logic [3:0] f;
      f = '0;
      if (!op_legal(op)) begin
         f[FLG_ILL] = 1'b1;
      end else begin
         f[FLG_OVF] = ovf & ((op == OP_ADD) | (op == OP_SUB));
         f[FLG_LT]  = lt  & (op == OP_SUB);
         f[FLG_NE]  = ne  & (op == OP_SUB);
      end
      return f;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping mod NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      // Scan from the far end down so the closest valid offset wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (valid_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = ID_W'(j);
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external alu among NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester grant counters and an illegal-op counter.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [5*NUM_REQ-1:0]   req_opcode,
   input  logic [5*NUM_REQ-1:0]   req_shamt,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   output logic [31:0]            alu_operandA,
   output logic [31:0]            alu_operandB,
   output logic [4:0]             alu_opcode,
   output logic [4:0]             alu_shiftamt,
   input  logic [31:0]            alu_result,
   input  logic                   alu_isNotEqual,
   input  logic                   alu_isLessThan,
   input  logic                   alu_overflow,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_result,
`ifdef ALU_ARB_STATS_EN
   output logic [16*NUM_REQ-1:0]  stat_grants,
   output logic [15:0]            stat_illegal,
`endif
   output logic [3:0]             rsp_flags
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [4:0]          op_q, sh_q;
   logic [31:0]         a_q, b_q;
   logic [ID_W-1:0]     id_q;
   logic                rsp_valid_q;
   logic [31:0]         rsp_result_q;
   logic [3:0]          rsp_flags_q;

   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gidx;
   logic                any;
   logic                load, exec_done, rsp_pop;
   logic [31:0]         res_d;
   logic [3:0]          flg_d;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (gidx),
      .any_o   (any)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      req_ready = '0;
      load      = 1'b0;
      exec_done = 1'b0;
      rsp_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               req_ready = gnt;
               load      = 1'b1;
               ptr_d     = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
               state_d   = EXEC;
            end
         end
         EXEC: begin
            exec_done = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_pop = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Illegal opcodes still drive the alu, but its result is replaced by zero.
   always_comb begin
      res_d = op_legal(op_q) ? alu_result : 32'd0;
      flg_d = mask_flags(op_q, alu_isNotEqual, alu_isLessThan, alu_overflow);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q <= '0;
         sh_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         id_q <= '0;
      end else if (load) begin
         op_q <= req_opcode[int'(gidx)*5 +: 5];
         sh_q <= req_shamt[int'(gidx)*5 +: 5];
         a_q  <= req_a[int'(gidx)*32 +: 32];
         b_q  <= req_b[int'(gidx)*32 +: 32];
         id_q <= gidx;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else if (exec_done) begin
         rsp_valid_q  <= 1'b1;
         rsp_result_q <= res_d;
         rsp_flags_q  <= flg_d;
      end else if (rsp_pop) begin
         rsp_valid_q  <= 1'b0;
      end
   end

   assign alu_operandA = a_q;
   assign alu_operandB = b_q;
   assign alu_opcode   = op_q;
   assign alu_shiftamt = sh_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_flags    = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] grant_cnt_q;
   logic [15:0]              ill_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_cnt_q <= '0;
         ill_cnt_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (load && gnt[i] && (grant_cnt_q[i] != 16'hFFFF))
               grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
         end
         if (exec_done && flg_d[FLG_ILL] && (ill_cnt_q != 16'hFFFF))
            ill_cnt_q <= ill_cnt_q + 16'd1;
      end
   end

   assign stat_grants  = grant_cnt_q;
   assign stat_illegal = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu attached to the alu_* ports.
module tb_alu_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [NUM_REQ-1:0]    req_valid, req_ready;
   logic [5*NUM_REQ-1:0]  req_opcode, req_shamt;
   logic [32*NUM_REQ-1:0] req_a, req_b;
   logic [31:0]           alu_operandA, alu_operandB, alu_result;
   logic [4:0]            alu_opcode, alu_shiftamt;
   logic                  alu_isNotEqual, alu_isLessThan, alu_overflow;
   logic                  rsp_valid, rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_result;
   logic [3:0]            rsp_flags;

   int nchk  = 0;
   int nfail = 0;

   alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_opcode     (req_opcode),
      .req_shamt      (req_shamt),
      .req_a          (req_a),
      .req_b          (req_b),
      .alu_operandA   (alu_operandA),
      .alu_operandB   (alu_operandB),
      .alu_opcode     (alu_opcode),
      .alu_shiftamt   (alu_shiftamt),
      .alu_result     (alu_result),
      .alu_isNotEqual (alu_isNotEqual),
      .alu_isLessThan (alu_isLessThan),
      .alu_overflow   (alu_overflow),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_id         (rsp_id),
      .rsp_result     (rsp_result),
      .rsp_flags      (rsp_flags)
   );

   // Unused opcodes return garbage and raw flags stay live so masking is exercised.
   always_comb begin
      logic [31:0] r;
      r              = 32'hDEADBEEF;
      alu_overflow   = 1'b1;
      alu_isNotEqual = (alu_operandA != alu_operandB);
      alu_isLessThan = ($signed(alu_operandA) < $signed(alu_operandB));
      case (alu_opcode)
         5'd0: begin
            r = alu_operandA + alu_operandB;
            alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (r[31] != alu_operandA[31]);
         end
         5'd1: begin
            r = alu_operandA - alu_operandB;
            alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (r[31] != alu_operandA[31]);
         end
         5'd2: r = alu_operandA & alu_operandB;
         5'd3: r = alu_operandA | alu_operandB;
         5'd4: r = alu_operandA << alu_shiftamt;
         5'd5: r = $unsigned($signed(alu_operandA) >>> alu_shiftamt);
         default: r = 32'hDEADBEEF;
      endcase
      alu_result = r;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
      req_opcode[5*i +: 5] = op;
      req_shamt[5*i +: 5]  = sh;
      req_a[32*i +: 32]    = a;
      req_b[32*i +: 32]    = b;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

   initial begin
      int ng, nr, last;
      req_valid  = '0;
      req_opcode = '0;
      req_shamt  = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;

      repeat (3) @(negedge clock);
      chk("rst_ready",  req_ready, 0);
      chk("rst_valid",  rsp_valid, 0);
      chk("rst_id",     rsp_id, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags",  rsp_flags, 0);
      chk("rst_opA",    alu_operandA, 0);
      chk("rst_opc",    alu_opcode, 0);
      reset = 1'b1;
      @(negedge clock);

      // add from requester 1
      set_req(1, 5'd0, 5'd0, 32'd7, 32'd5);
      req_valid = 4'b0010;
      #1 chk("t1_ready", req_ready, 4'b0010);
      @(negedge clock);
      req_valid = '0;
      #1;
      chk("t1_exec_ready", req_ready, 0);
      chk("t1_exec_valid", rsp_valid, 0);
      chk("t1_opA", alu_operandA, 7);
      chk("t1_opB", alu_operandB, 5);
      @(negedge clock);
      chk("t1_valid",  rsp_valid, 1);
      chk("t1_id",     rsp_id, 1);
      chk("t1_result", rsp_result, 12);
      chk("t1_flags",  rsp_flags, 0);
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("t1_pop", rsp_valid, 0);
      rsp_ready = 1'b0;

      // sub overflow from requester 0, response back-pressured
      set_req(0, 5'd1, 5'd0, 32'h80000000, 32'd1);
      req_valid = 4'b0001;
      #1 chk("t2_ready", req_ready, 4'b0001);
      @(negedge clock);
      req_valid = '0;
      @(negedge clock);
      chk("t2_result", rsp_result, 32'h7FFFFFFF);
      chk("t2_flags",  rsp_flags, 4'b0111);
      chk("t2_id",     rsp_id, 0);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("t2_hold_valid",  rsp_valid, 1);
         chk("t2_hold_result", rsp_result, 32'h7FFFFFFF);
         chk("t2_hold_flags",  rsp_flags, 4'b0111);
         chk("t2_hold_ready",  req_ready, 0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("t2_pop", rsp_valid, 0);
      rsp_ready = 1'b0;

      // reset pulse so the round-robin run starts at ptr 0
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'd0, 5'd0, 32'(i + 1), 32'd100);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      ng = 0; nr = 0; last = -1;
      for (int c = 0; c < 18; c++) begin
         #1;
         if (req_ready != 0) begin
            chk("rr_gnt", req_ready, 64'(1) << (ng % 4));
            if (last >= 0) chk("rr_gap", c - last, 3);
            last = c;
            ng++;
         end
         if (rsp_valid) begin
            chk("rr_id",  rsp_id, nr % 4);
            chk("rr_res", rsp_result, (nr % 4) + 101);
            nr++;
         end
         @(negedge clock);
      end
      chk("rr_ngrant", ng, 6);
      chk("rr_nrsp",   nr, 6);
      req_valid = '0;
      rsp_ready = 1'b0;

      // shifts from requester 2 (ptr now 2, then 3)
      set_req(2, 5'd5, 5'd4, 32'hF0000000, 32'd0);
      req_valid = 4'b0100;
      #1 chk("t4_ready", req_ready, 4'b0100);
      @(negedge clock);
      req_valid = '0;
      #1;
      chk("t4_shamt", alu_shiftamt, 4);
      chk("t4_opc",   alu_opcode, 5);
      @(negedge clock);
      chk("t4_result", rsp_result, 32'hFF000000);
      chk("t4_flags",  rsp_flags, 0);
      chk("t4_id",     rsp_id, 2);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;

      set_req(2, 5'd4, 5'd31, 32'd1, 32'd0);
      req_valid = 4'b0100;
      #1 chk("t4b_ready", req_ready, 4'b0100);
      @(negedge clock);
      req_valid = '0;
      @(negedge clock);
      chk("t4b_result", rsp_result, 32'h80000000);
      chk("t4b_flags",  rsp_flags, 0);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;

      // illegal opcode from requester 3
      set_req(3, 5'd9, 5'd0, 32'd5, 32'd6);
      req_valid = 4'b1000;
      #1 chk("t5_ready", req_ready, 4'b1000);
      @(negedge clock);
      req_valid = '0;
      #1;
      chk("t5_opc", alu_opcode, 9);
      chk("t5_opA", alu_operandA, 5);
      @(negedge clock);
      chk("t5_result", rsp_result, 0);
      chk("t5_flags",  rsp_flags, 4'b1000);
      chk("t5_id",     rsp_id, 3);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;

      // async reset while EXEC
      set_req(1, 5'd0, 5'd0, 32'd3, 32'd4);
      req_valid = 4'b0010;
      @(negedge clock);
      req_valid = '0;
      #1 reset = 1'b0;
      #1;
      chk("t6_valid", rsp_valid, 0);
      chk("t6_ready", req_ready, 0);
      chk("t6_opA",   alu_operandA, 0);
      @(negedge clock);
      reset = 1'b1;
      set_req(0, 5'd0, 5'd0, 32'd1, 32'd1);
      req_valid = 4'b1111;
      #1 chk("t6_first_gnt", req_ready, 4'b0001);
      @(negedge clock);
      req_valid = '0;
      @(negedge clock);
      chk("t6_result", rsp_result, 2);
      chk("t6_id",     rsp_id, 0);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
